// File: rtl/io_sw_conditioner.sv
// Switch/button input conditioner: two-flop synchroniser and per-bit debounce,
// producing a stable level, rise/fall pulses and sticky write-1-to-clear change flags.
module io_sw_conditioner #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sw_raw,
  input  logic [WIDTH-1:0] i_evt_clr,
  output logic [WIDTH-1:0] o_io_sw,
  output logic [WIDTH-1:0] o_sw_rise,
  output logic [WIDTH-1:0] o_sw_fall,
  output logic [WIDTH-1:0] o_evt,
  output logic             o_evt_any
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync_s1;
  logic [WIDTH-1:0] sync_s2;
  logic [WIDTH-1:0] stable;
  logic [CNT_W-1:0] cnt      [WIDTH];

  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;
  logic [WIDTH-1:0] evt_nxt;
  logic [CNT_W-1:0] cnt_nxt  [WIDTH];

  // Only the second synchroniser stage feeds the debounce logic.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= i_sw_raw;
      sync_s2 <= sync_s1;
    end
  end

  // Any sample matching the stable value restarts that channel's count.
  always_comb begin
    stable_nxt = stable;
    rise_nxt   = '0;
    fall_nxt   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync_s2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_nxt[i] = sync_s2[i];
          rise_nxt[i]   = sync_s2[i];
          fall_nxt[i]   = ~sync_s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
      end
    end
    // A transition on the same edge as a clear keeps the flag set.
    evt_nxt = (o_evt & ~i_evt_clr) | rise_nxt | fall_nxt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stable    <= '0;
      o_sw_rise <= '0;
      o_sw_fall <= '0;
      o_evt     <= '0;
      o_evt_any <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable    <= stable_nxt;
      o_sw_rise <= rise_nxt;
      o_sw_fall <= fall_nxt;
      o_evt     <= evt_nxt;
      o_evt_any <= |evt_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign o_io_sw = stable;

endmodule
